// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register: FSM state
// encodings, the default bubble control value and packed control-field bit
// positions common to every stage boundary instance.
package pipe_pkg;

   typedef logic [1:0] state_t;

   // State encoding doubles as the occupancy count (0/1/2 entries).
   localparam state_t ST_EMPTY = 2'b00;
   localparam state_t ST_BUSY  = 2'b01;
   localparam state_t ST_FULL  = 2'b10;

   // Control value carried by bubbles and written by flush.
   localparam int CTRL_NOP_DEF = 0;

   // Packed control-field bit positions.
   localparam int CTRL_BIT_REG_WRITE  = 0;
   localparam int CTRL_BIT_MEM_WRITE  = 1;
   localparam int CTRL_BIT_MEM_READ   = 2;
   localparam int CTRL_BIT_BRANCH     = 3;
   localparam int CTRL_BIT_JUMP       = 4;
   localparam int CTRL_BIT_ALU_SRC    = 5;
   localparam int CTRL_BIT_MEM_TO_REG = 6;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus between two CPU stages: a control field and a data field
// travel together, qualified by valid and back-pressured by ready.
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   // Producer side drives the entry, consumer side drives ready.
   modport master (output valid, output ctrl, output data, input  ready);
   modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry (control + data) with load and a clear that only
// returns the control field to the NOP value, leaving data untouched.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                CTRL_W   = 8,
   parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load,
   input  logic              clr,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [DATA_W-1:0] q_data
);

   // Entry register: clear beats load so a flush always leaves a NOP behind.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         q_ctrl <= CTRL_NOP;
         q_data <= '0;
      end else if (clr) begin
         q_ctrl <= CTRL_NOP;
      end else if (load) begin
         q_ctrl <= d_ctrl;
         q_data <= d_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two CPU stages. Main slot feeds the
// downstream bus; an optional skid slot absorbs the one entry that arrives
// while downstream stalls, so upstream ready can come straight from a flop.
// Flush empties the stage and counts discarded valid entries.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                CTRL_W   = 8,
   parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF),
   parameter int                SKID     = 1,
   parameter int                CNT_W    = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               bubble_i,
   pipe_stage_reg_if.slave    up,
   pipe_stage_reg_if.master   dn,
   output logic [1:0]         occ_o,
   output logic [CNT_W-1:0]   drop_cnt_o
);

   localparam bit HAS_SKID = (SKID != 0);

   state_t            state, state_nxt;
   logic              acc, emit;
   logic              main_load, main_clr, main_from_skid;
   logic              skid_load, skid_clr;
   logic [CTRL_W-1:0] main_d_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_d_data, skid_data;
   logic [1:0]        drop_inc;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   assign acc      = up.valid & up.ready;
   assign emit     = dn.valid & dn.ready;
   assign occ_o    = state;
   assign drop_inc = state + {1'b0, acc};

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   // Next state: flush dominates, otherwise follow accept/emit.
   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (acc) state_nxt = ST_BUSY;
            ST_BUSY: begin
               if (acc && !emit && HAS_SKID) state_nxt = ST_FULL;
               else if (!acc && emit)        state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (emit) state_nxt = ST_BUSY;
            default:  state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs and slot controls; in FULL the main slot refills from skid.
   always_comb begin
      up.ready       = ~bubble_i & (HAS_SKID ? (state != ST_FULL)
                                             : ((state == ST_EMPTY) | dn.ready));
      dn.valid       = (state != ST_EMPTY);
      main_load      = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush_i) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: main_load = acc;
            ST_BUSY: begin
               if (acc && emit)                   main_load = 1'b1;
               else if (acc && !emit && HAS_SKID) skid_load = 1'b1;
               else if (!acc && emit)             main_clr  = 1'b1;
            end
            ST_FULL: begin
               main_load      = emit;
               main_from_skid = 1'b1;
            end
            default: main_clr = 1'b1;
         endcase
      end
      main_d_ctrl = main_from_skid ? skid_ctrl : up.ctrl;
      main_d_data = main_from_skid ? skid_data : up.data;
   end

   // Drop counter: entries held plus any entry accepted in the flush cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       drop_cnt_o <= '0;
      else if (flush_i) drop_cnt_o <= sat_add(drop_cnt_o, drop_inc);
   end

   // ---- stage boundary: main slot drives the downstream bus ----
   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_main (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load   (main_load),
      .clr    (main_clr),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .q_ctrl (dn.ctrl),
      .q_data (dn.data)
   );

   if (HAS_SKID) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_skid (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .load   (skid_load),
         .clr    (skid_clr),
         .d_ctrl (up.ctrl),
         .d_data (up.data),
         .q_ctrl (skid_ctrl),
         .q_data (skid_data)
      );
   end else begin : g_no_skid
      logic unused_skid;
      assign unused_skid = skid_load | skid_clr;
      assign skid_ctrl   = CTRL_NOP;
      assign skid_data   = '0;
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, skid back-pressure, flush,
// bubble insertion, counter saturation and asynchronous reset.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, bubble, flush4;
   logic [1:0]  occ, occ4;
   logic [15:0] drop;
   logic [3:0]  drop4;
   int          n_assert = 0;
   int          n_fail   = 0;

   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) up_if ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) dn_if ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) up4_if ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) dn4_if ();

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_NOP(8'h00), .SKID(1), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .bubble_i(bubble),
      .up(up_if), .dn(dn_if), .occ_o(occ), .drop_cnt_o(drop)
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_NOP(8'h00), .SKID(1), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst_n), .flush_i(flush4), .bubble_i(1'b0),
      .up(up4_if), .dn(dn4_if), .occ_o(occ4), .drop_cnt_o(drop4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [7:0] c);
      up_if.valid = 1'b1;
      up_if.data  = d;
      up_if.ctrl  = c;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; bubble = 1'b0; flush4 = 1'b0;
      up_if.valid = 1'b0; up_if.ctrl = '0; up_if.data = '0; dn_if.ready = 1'b0;
      up4_if.valid = 1'b0; up4_if.ctrl = '0; up4_if.data = '0; dn4_if.ready = 1'b1;
      repeat (2) tick();

      // reset state
      chk("rst_dn_valid", dn_if.valid, 0);
      chk("rst_up_ready", up_if.ready, 1);
      chk("rst_occ", occ, 0);
      chk("rst_drop", drop, 0);
      chk("rst_dn_ctrl", dn_if.ctrl, 0);
      chk("rst_dn_data", dn_if.data, 0);
      chk("rst_drop4", drop4, 0);
      rst_n = 1'b1;

      // 8 back-to-back entries, first is data 4 / ctrl 15
      dn_if.ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         push(32'h4 + 32'(4 * k), 8'h15 + 8'(k));
         tick();
         chk("stream_valid", dn_if.valid, 1);
         chk("stream_data", dn_if.data, 32'h4 + 32'(4 * k));
         chk("stream_ctrl", dn_if.ctrl, 8'h15 + 8'(k));
         chk("stream_occ", occ, 1);
      end
      up_if.valid = 1'b0;
      tick();
      chk("drain_valid", dn_if.valid, 0);
      chk("drain_ctrl_nop", dn_if.ctrl, 0);
      chk("drain_data_hold", dn_if.data, 32'h20);
      chk("drain_occ", occ, 0);

      // skid: A,B accepted while stalled, C waits
      dn_if.ready = 1'b0;
      push(32'hA, 8'h0A);
      tick();
      chk("skidA_occ", occ, 1);
      chk("skidA_ready", up_if.ready, 1);
      push(32'hB, 8'h0B);
      tick();
      chk("skidB_occ", occ, 2);
      chk("skidB_ready", up_if.ready, 0);
      chk("skidB_data", dn_if.data, 32'hA);
      push(32'hC, 8'h0C);
      tick();
      chk("skidC_occ", occ, 2);
      chk("skidC_data", dn_if.data, 32'hA);
      dn_if.ready = 1'b1;
      tick();
      chk("skid_outB_data", dn_if.data, 32'hB);
      chk("skid_outB_ctrl", dn_if.ctrl, 8'h0B);
      chk("skid_outB_occ", occ, 1);
      chk("skid_outB_ready", up_if.ready, 1);
      tick();
      chk("skid_outC_data", dn_if.data, 32'hC);
      chk("skid_outC_ctrl", dn_if.ctrl, 8'h0C);
      chk("skid_outC_valid", dn_if.valid, 1);
      up_if.valid = 1'b0;
      tick();
      chk("skid_end_valid", dn_if.valid, 0);
      chk("skid_end_occ", occ, 0);

      // flush one held entry, no input
      dn_if.ready = 1'b0;
      push(32'hD, 8'h0D);
      tick();
      chk("flD_occ", occ, 1);
      up_if.valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flD_drop", drop, 1);
      chk("flD_occ0", occ, 0);
      chk("flD_valid", dn_if.valid, 0);
      chk("flD_ctrl", dn_if.ctrl, 0);
      chk("flD_data_kept", dn_if.data, 32'hD);

      // flush with two held and one offered
      push(32'hE, 8'h0E);
      tick();
      push(32'hF, 8'h0F);
      tick();
      chk("flFULL_occ2", occ, 2);
      push(32'h10, 8'h10);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      up_if.valid = 1'b0;
      chk("flFULL_occ", occ, 0);
      chk("flFULL_valid", dn_if.valid, 0);
      chk("flFULL_ctrl", dn_if.ctrl, 0);
      chk("flFULL_drop", drop, 3);
      dn_if.ready = 1'b1;
      tick();
      chk("flFULL_gone", dn_if.valid, 0);
      chk("flFULL_ready", up_if.ready, 1);

      // flush in BUSY while accepting: held + accepted both count
      push(32'h11, 8'h11);
      tick();
      push(32'h12, 8'h12);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      up_if.valid = 1'b0;
      chk("flBUSY_drop", drop, 5);
      chk("flBUSY_valid", dn_if.valid, 0);

      // bubble during streaming
      push(32'h100, 8'h21);
      tick();
      chk("bub_x0_data", dn_if.data, 32'h100);
      push(32'h101, 8'h22);
      bubble = 1'b1;
      #1;
      chk("bub_up_ready", up_if.ready, 0);
      tick();
      bubble = 1'b0;
      chk("bub_slot_valid", dn_if.valid, 0);
      chk("bub_slot_ctrl", dn_if.ctrl, 0);
      tick();
      chk("bub_x1_valid", dn_if.valid, 1);
      chk("bub_x1_data", dn_if.data, 32'h101);
      chk("bub_x1_ctrl", dn_if.ctrl, 8'h22);
      push(32'h102, 8'h23);
      tick();
      chk("bub_x2_data", dn_if.data, 32'h102);
      up_if.valid = 1'b0;
      tick();
      chk("bub_end_valid", dn_if.valid, 0);

      // saturation on the 4-bit counter: one entry discarded per flush cycle
      up4_if.valid = 1'b1; up4_if.data = 32'h55; up4_if.ctrl = 8'h01;
      flush4 = 1'b1;
      repeat (5) tick();
      chk("sat_drop5", drop4, 4'h5);
      repeat (15) tick();
      chk("sat_dropF", drop4, 4'hF);
      chk("sat_valid", dn4_if.valid, 0);
      flush4 = 1'b0;
      up4_if.valid = 1'b0;

      // asynchronous reset mid-cycle with two entries held
      dn_if.ready = 1'b0;
      push(32'h200, 8'h31);
      tick();
      push(32'h201, 8'h32);
      tick();
      up_if.valid = 1'b0;
      chk("arst_pre_occ", occ, 2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", dn_if.valid, 0);
      chk("arst_occ", occ, 0);
      chk("arst_drop", drop, 0);
      chk("arst_ctrl", dn_if.ctrl, 0);
      chk("arst_ready", up_if.ready, 1);
      chk("arst_drop4", drop4, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_post_occ", occ, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
